// File: rtl/lsu_axi_store_ctrl.sv
// lsu_axi_store_ctrl: LSU store sequencer driving the AXI write channels.
// Accepts one store command and issues a single AW request carrying burst count
// and stride. It then streams every W beat out of the ORAM through a 2-entry
// prefetch FIFO and collects one B response per burst.
// Optional build macro: LSU_ST_PERF_EN enables the W backpressure stall counter.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | waiting for a command, cmd_rdy=1
// ST_AW   | AW request presented, waiting for axi_lsu_awrdy
// ST_W    | prefetching ORAM and streaming W beats; B responses counted
// ST_B    | all beats sent, waiting for the remaining B responses
module lsu_axi_store_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 10,
    parameter int ORAM_AW    = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_vld,
    output logic                    cmd_rdy,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [7:0]              cmd_len,
    input  logic [2:0]              cmd_size,
    input  logic [2:0]              cmd_str,
    input  logic [3:0]              cmd_num,
    input  logic [ORAM_AW-1:0]      cmd_oram_addr,
    output logic                    oram_rd_en,
    output logic [ORAM_AW-1:0]      oram_rd_addr,
    input  logic [DATA_WIDTH-1:0]   oram_rd_data,
    output logic [7:0]              lsu_axi_awid,
    output logic [ADDR_WIDTH-1:0]   lsu_axi_awaddr,
    output logic [7:0]              lsu_axi_awlen,
    output logic [2:0]              lsu_axi_awsize,
    output logic [1:0]              lsu_axi_awburst,
    output logic [2:0]              lsu_axi_awstr,
    output logic [7:0]              lsu_axi_awnum,
    output logic                    lsu_axi_awvld,
    output logic [ORAM_AW-1:0]      lsu_axi_oram_addr,
    input  logic                    axi_lsu_awrdy,
    output logic [DATA_WIDTH-1:0]   lsu_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] lsu_axi_wstrb,
    output logic                    lsu_axi_wlast,
    output logic                    lsu_axi_wvld,
    input  logic                    axi_lsu_wrdy,
    input  logic                    axi_lsu_bvld,
    input  logic [1:0]              axi_lsu_bresp,
    output logic                    lsu_axi_brdy,
    output logic                    st_done,
    output logic                    st_err,
    output logic [15:0]             st_perf_stall
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_AW   = 2'd1;
    localparam logic [1:0] ST_W    = 2'd2;
    localparam logic [1:0] ST_B    = 2'd3;

    logic [1:0]            state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [2:0]            size_q;
    logic [2:0]            str_q;
    logic [3:0]            num_q;
    logic [ORAM_AW-1:0]    oram_q;

    logic [11:0]           total;
    logic [11:0]           rd_cnt_q;
    logic [11:0]           beat_cnt_q;
    logic [7:0]            burst_cnt_q;
    logic [3:0]            resp_cnt_q;
    logic [3:0]            resp_next;
    logic                  err_q;

    logic                  inflight_q;
    logic [DATA_WIDTH-1:0] fifo_q [2];
    logic                  wp_q;
    logic                  rp_q;
    logic [1:0]            fifo_cnt_q;
    logic [1:0]            credit;

    logic                  accept;
    logic                  w_fire;
    logic                  b_fire;
    logic                  last_beat;
    logic                  resp_done;

    assign accept    = cmd_vld && (state_q == ST_IDLE);
    assign total     = 12'(num_q) * (12'(len_q) + 12'd1);
    assign w_fire    = lsu_axi_wvld && axi_lsu_wrdy;
    assign b_fire    = axi_lsu_bvld && lsu_axi_brdy;
    assign last_beat = w_fire && (beat_cnt_q == total - 12'd1);
    assign resp_next = resp_cnt_q + {3'b0, b_fire};
    assign resp_done = (state_q == ST_B) && (resp_next >= num_q);

    // Slots already spoken for, net of a beat leaving this cycle; counting the pop keeps 1 beat/cycle.
    assign credit = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, w_fire};

    assign cmd_rdy           = (state_q == ST_IDLE);
    assign oram_rd_en        = (state_q == ST_W) && (rd_cnt_q < total) && (credit < 2'd2);
    assign oram_rd_addr      = oram_q + ORAM_AW'(rd_cnt_q);

    assign lsu_axi_awid      = 8'h00;
    assign lsu_axi_awaddr    = addr_q;
    assign lsu_axi_awlen     = len_q;
    assign lsu_axi_awsize    = size_q;
    assign lsu_axi_awburst   = 2'b01;
    assign lsu_axi_awstr     = str_q;
    assign lsu_axi_awnum     = {4'b0, num_q};
    assign lsu_axi_awvld     = (state_q == ST_AW);
    assign lsu_axi_oram_addr = oram_q;

    assign lsu_axi_wvld      = (state_q == ST_W) && (fifo_cnt_q != 2'd0);
    assign lsu_axi_wdata     = fifo_q[rp_q];
    assign lsu_axi_wstrb     = '1;
    assign lsu_axi_wlast     = lsu_axi_wvld && (burst_cnt_q == len_q);
    assign lsu_axi_brdy      = (state_q == ST_W) || (state_q == ST_B);

    assign st_done           = resp_done;
    assign st_err            = resp_done && (err_q || (b_fire && (axi_lsu_bresp != 2'b00)));

    // Sequencer state transitions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (accept)        state_q <= ST_AW;
                ST_AW:   if (axi_lsu_awrdy) state_q <= ST_W;
                ST_W:    if (last_beat)     state_q <= ST_B;
                ST_B:    if (resp_done)     state_q <= ST_IDLE;
                default:                    state_q <= ST_IDLE;
            endcase
        end
    end

    // Command capture; fields stay frozen until the next accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            len_q  <= '0;
            size_q <= '0;
            str_q  <= '0;
            num_q  <= '0;
            oram_q <= '0;
        end else if (accept) begin
            addr_q <= cmd_addr;
            len_q  <= cmd_len;
            size_q <= cmd_size;
            str_q  <= cmd_str;
            num_q  <= (cmd_num == 4'd0) ? 4'd1 : cmd_num;
            oram_q <= cmd_oram_addr;
        end
    end

    // Read-issue, beat, burst-beat and response counters plus sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_q    <= '0;
            beat_cnt_q  <= '0;
            burst_cnt_q <= '0;
            resp_cnt_q  <= '0;
            err_q       <= 1'b0;
        end else if (accept) begin
            rd_cnt_q    <= '0;
            beat_cnt_q  <= '0;
            burst_cnt_q <= '0;
            resp_cnt_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            if (oram_rd_en) rd_cnt_q <= rd_cnt_q + 12'd1;
            if (w_fire) begin
                beat_cnt_q  <= beat_cnt_q + 12'd1;
                burst_cnt_q <= (burst_cnt_q == len_q) ? 8'd0 : burst_cnt_q + 8'd1;
            end
            if (b_fire) begin
                resp_cnt_q <= resp_next;
                err_q      <= err_q || (axi_lsu_bresp != 2'b00);
            end
        end
    end

    // FIFO occupancy and pointers; reset drops any in-flight ORAM read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= 1'b0;
            wp_q       <= 1'b0;
            rp_q       <= 1'b0;
            fifo_cnt_q <= '0;
        end else begin
            inflight_q <= oram_rd_en;
            if (inflight_q) wp_q <= ~wp_q;
            if (w_fire)     rp_q <= ~rp_q;
            fifo_cnt_q <= fifo_cnt_q + {1'b0, inflight_q} - {1'b0, w_fire};
        end
    end

    // FIFO storage; contents are only meaningful under fifo_cnt_q.
    always_ff @(posedge clk) begin
        if (inflight_q) fifo_q[wp_q] <= oram_rd_data;
    end

`ifdef LSU_ST_PERF_EN
    logic [15:0] stall_q;

    // Saturating count of cycles a beat waits on wrdy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (accept) begin
            stall_q <= '0;
        end else if (lsu_axi_wvld && !axi_lsu_wrdy && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign st_perf_stall = stall_q;
`else
    assign st_perf_stall = 16'h0;
`endif

endmodule

// File: tb/tb_lsu_axi_store_ctrl.sv
// Self-checking bench for lsu_axi_store_ctrl: randomized handshakes checked
// against a beat/response-level model of the store transaction.
module tb_lsu_axi_store_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_vld;
    logic        cmd_rdy;
    logic [9:0]  cmd_addr;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [2:0]  cmd_str;
    logic [3:0]  cmd_num;
    logic [11:0] cmd_oram_addr;
    logic        oram_rd_en;
    logic [11:0] oram_rd_addr;
    logic [63:0] oram_rd_data;
    logic [7:0]  lsu_axi_awid;
    logic [9:0]  lsu_axi_awaddr;
    logic [7:0]  lsu_axi_awlen;
    logic [2:0]  lsu_axi_awsize;
    logic [1:0]  lsu_axi_awburst;
    logic [2:0]  lsu_axi_awstr;
    logic [7:0]  lsu_axi_awnum;
    logic        lsu_axi_awvld;
    logic [11:0] lsu_axi_oram_addr;
    logic        axi_lsu_awrdy;
    logic [63:0] lsu_axi_wdata;
    logic [7:0]  lsu_axi_wstrb;
    logic        lsu_axi_wlast;
    logic        lsu_axi_wvld;
    logic        axi_lsu_wrdy;
    logic        axi_lsu_bvld;
    logic [1:0]  axi_lsu_bresp;
    logic        lsu_axi_brdy;
    logic        st_done;
    logic        st_err;
    logic [15:0] st_perf_stall;

    int checks = 0;
    int errors = 0;

    logic [63:0] oram [4096];
    logic [1:0]  bresp_tab [16];

    lsu_axi_store_ctrl dut (
        .clk(clk), .rst(rst),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cmd_size(cmd_size), .cmd_str(cmd_str), .cmd_num(cmd_num), .cmd_oram_addr(cmd_oram_addr),
        .oram_rd_en(oram_rd_en), .oram_rd_addr(oram_rd_addr), .oram_rd_data(oram_rd_data),
        .lsu_axi_awid(lsu_axi_awid), .lsu_axi_awaddr(lsu_axi_awaddr), .lsu_axi_awlen(lsu_axi_awlen),
        .lsu_axi_awsize(lsu_axi_awsize), .lsu_axi_awburst(lsu_axi_awburst), .lsu_axi_awstr(lsu_axi_awstr),
        .lsu_axi_awnum(lsu_axi_awnum), .lsu_axi_awvld(lsu_axi_awvld), .lsu_axi_oram_addr(lsu_axi_oram_addr),
        .axi_lsu_awrdy(axi_lsu_awrdy),
        .lsu_axi_wdata(lsu_axi_wdata), .lsu_axi_wstrb(lsu_axi_wstrb), .lsu_axi_wlast(lsu_axi_wlast),
        .lsu_axi_wvld(lsu_axi_wvld), .axi_lsu_wrdy(axi_lsu_wrdy),
        .axi_lsu_bvld(axi_lsu_bvld), .axi_lsu_bresp(axi_lsu_bresp), .lsu_axi_brdy(lsu_axi_brdy),
        .st_done(st_done), .st_err(st_err), .st_perf_stall(st_perf_stall)
    );

    always #5 clk = ~clk;

    // ORAM model: synchronous read, data one cycle after the strobe.
    always @(posedge clk) begin
        if (oram_rd_en) oram_rd_data <= oram[oram_rd_addr];
    end

    task automatic drive_idle();
        cmd_vld       = 1'b0;
        cmd_addr      = '0;
        cmd_len       = '0;
        cmd_size      = '0;
        cmd_str       = '0;
        cmd_num       = '0;
        cmd_oram_addr = '0;
        axi_lsu_awrdy = 1'b0;
        axi_lsu_wrdy  = 1'b0;
        axi_lsu_bvld  = 1'b0;
        axi_lsu_bresp = 2'b00;
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if ({cmd_rdy, lsu_axi_awvld, lsu_axi_wvld, lsu_axi_wlast, oram_rd_en, lsu_axi_brdy, st_done, st_err}
            !== 8'b1000_0000) begin
            errors++;
            $display("FAIL %s idle_outputs got %b exp 10000000", tag,
                     {cmd_rdy, lsu_axi_awvld, lsu_axi_wvld, lsu_axi_wlast, oram_rd_en, lsu_axi_brdy, st_done, st_err});
        end
    endtask

    // One store command driven to completion (or aborted after abort_cyc cycles).
    // wmode: 0 wrdy always 1, 1 wrdy toggles, 2 wrdy random.
    task automatic run_cmd(input logic [9:0] a, input logic [7:0] len, input logic [2:0] sz,
                           input logic [2:0] str, input logic [3:0] num, input logic [11:0] oa,
                           input int wmode, input int abort_cyc);
        int numq, tot, beats, reads, resps, pend, stall, cyc, exp_stall;
        bit err_exp, got_done, was_stall, aw_acc, exp_last, done_exp;
        logic [63:0] held_d;
        logic        held_l;
        logic [11:0] exp_addr;
        numq = (num == 4'd0) ? 1 : int'(num);
        tot = numq * (int'(len) + 1);
        beats = 0; reads = 0; resps = 0; pend = 0; stall = 0; cyc = 0;
        err_exp = 0; got_done = 0; was_stall = 0; aw_acc = 0;
        held_d = '0; held_l = 1'b0;

        @(negedge clk);
        drive_idle();
        cmd_vld = 1'b1; cmd_addr = a; cmd_len = len; cmd_size = sz;
        cmd_str = str; cmd_num = num; cmd_oram_addr = oa;
        #1;
        checks++;
        if (cmd_rdy !== 1'b1) begin
            errors++;
            $display("FAIL cmd_rdy_on_accept got %b exp 1", cmd_rdy);
        end

        while (!got_done && cyc < 4000 && !(abort_cyc > 0 && cyc >= abort_cyc)) begin
            @(negedge clk);
            cyc++;
            cmd_vld       = 1'($urandom_range(0, 1));
            cmd_addr      = 10'($urandom);
            cmd_len       = 8'($urandom);
            cmd_size      = 3'($urandom);
            cmd_str       = 3'($urandom);
            cmd_num       = 4'($urandom);
            cmd_oram_addr = 12'($urandom);
            axi_lsu_awrdy = 1'($urandom_range(0, 1));
            case (wmode)
                0:       axi_lsu_wrdy = 1'b1;
                1:       axi_lsu_wrdy = (cyc % 2 == 1);
                default: axi_lsu_wrdy = 1'($urandom_range(0, 1));
            endcase
            if (pend > 0 && $urandom_range(0, 2) != 0) begin
                axi_lsu_bvld  = 1'b1;
                axi_lsu_bresp = bresp_tab[resps];
            end else begin
                axi_lsu_bvld  = 1'b0;
                axi_lsu_bresp = 2'($urandom);
            end
            #1;

            checks++;
            if (cmd_rdy !== 1'b0) begin
                errors++;
                $display("FAIL cmd_rdy_busy cyc %0d got %b exp 0", cyc, cmd_rdy);
            end

            if (lsu_axi_awvld === 1'b1) begin
                checks++;
                if (aw_acc || {lsu_axi_awid, lsu_axi_awaddr, lsu_axi_awlen, lsu_axi_awsize, lsu_axi_awburst,
                               lsu_axi_awstr, lsu_axi_awnum, lsu_axi_oram_addr}
                              !== {8'h00, a, len, sz, 2'b01, str, 8'(numq), oa}) begin
                    errors++;
                    $display("FAIL aw_request acc %b got %h/%h/%h/%h/%h/%h/%h exp %h/%h/%h/%h/%h/%h", aw_acc,
                             lsu_axi_awid, lsu_axi_awaddr, lsu_axi_awlen, lsu_axi_awsize, lsu_axi_awstr,
                             lsu_axi_awnum, lsu_axi_oram_addr, a, len, sz, str, numq, oa);
                end
                if (axi_lsu_awrdy) aw_acc = 1;
            end

            if (oram_rd_en === 1'b1) begin
                exp_addr = oa + 12'(reads);
                checks++;
                if (reads >= tot || oram_rd_addr !== exp_addr) begin
                    errors++;
                    $display("FAIL oram_rd_addr read %0d got %h exp %h (total %0d)", reads, oram_rd_addr, exp_addr, tot);
                end
                reads++;
            end

            if (lsu_axi_wvld === 1'b1) begin
                exp_last = ((beats % (int'(len) + 1)) == int'(len));
                checks++;
                if (beats >= tot) begin
                    errors++;
                    $display("FAIL extra_beat got beat %0d exp total %0d", beats, tot);
                end else if (lsu_axi_wdata !== oram[12'(int'(oa) + beats)] || lsu_axi_wlast !== exp_last
                             || lsu_axi_wstrb !== 8'hFF) begin
                    errors++;
                    $display("FAIL w_beat %0d got %h last %b strb %h exp %h last %b strb ff", beats,
                             lsu_axi_wdata, lsu_axi_wlast, lsu_axi_wstrb, oram[12'(int'(oa) + beats)], exp_last);
                end
                if (was_stall) begin
                    checks++;
                    if (lsu_axi_wdata !== held_d || lsu_axi_wlast !== held_l) begin
                        errors++;
                        $display("FAIL w_stall_stable got %h/%b exp %h/%b", lsu_axi_wdata, lsu_axi_wlast, held_d, held_l);
                    end
                end
                if (axi_lsu_wrdy) begin
                    beats++;
                    if (exp_last) pend++;
                    was_stall = 0;
                end else begin
                    stall++;
                    was_stall = 1;
                    held_d = lsu_axi_wdata;
                    held_l = lsu_axi_wlast;
                end
            end else if (was_stall) begin
                checks++;
                errors++;
                $display("FAIL w_stall_dropped got wvld %b exp 1", lsu_axi_wvld);
                was_stall = 0;
            end

            done_exp = 0;
            if (axi_lsu_bvld) begin
                checks++;
                if (lsu_axi_brdy !== 1'b1) begin
                    errors++;
                    $display("FAIL brdy got %b exp 1", lsu_axi_brdy);
                end else begin
                    err_exp = err_exp | (axi_lsu_bresp != 2'b00);
                    resps++;
                    pend--;
                    done_exp = (resps == numq);
                end
            end

            checks++;
            if (st_done !== done_exp) begin
                errors++;
                $display("FAIL st_done cyc %0d got %b exp %b (beats %0d resps %0d)", cyc, st_done, done_exp, beats, resps);
            end
            if (st_done === 1'b1) begin
                got_done = 1;
                checks++;
                if (st_err !== err_exp) begin
                    errors++;
                    $display("FAIL st_err got %b exp %b", st_err, err_exp);
                end
            end
        end

        if (abort_cyc > 0 && !got_done) return;

        if (!got_done) begin
            checks++;
            errors++;
            $display("FAIL timeout got no st_done exp done within 4000 cycles");
        end

        @(negedge clk);
        drive_idle();
        #1;
        check_idle_outputs("post_done");
        checks++;
        if (beats != tot || reads != tot || resps != numq) begin
            errors++;
            $display("FAIL totals got beats %0d reads %0d resps %0d exp %0d %0d %0d", beats, reads, resps, tot, tot, numq);
        end
`ifdef LSU_ST_PERF_EN
        exp_stall = (stall > 65535) ? 65535 : stall;
`else
        exp_stall = 0;
`endif
        checks++;
        if (st_perf_stall !== 16'(exp_stall)) begin
            errors++;
            $display("FAIL perf_stall got %0d exp %0d", st_perf_stall, exp_stall);
        end
    endtask

    task automatic set_bresp_ok();
        for (int i = 0; i < 16; i++) bresp_tab[i] = 2'b00;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        #1;
        check_idle_outputs("reset");
        checks++;
        if (st_perf_stall !== 16'h0) begin
            errors++;
            $display("FAIL reset_perf got %h exp 0", st_perf_stall);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle_outputs("reset_release");
    endtask

    task automatic test_single_burst();
        set_bresp_ok();
        run_cmd(10'h123, 8'd3, 3'd3, 3'b000, 4'd1, 12'h010, 0, 0);
    endtask

    task automatic test_multi_burst();
        set_bresp_ok();
        run_cmd(10'h040, 8'd1, 3'd3, 3'b001, 4'd3, 12'h200, 2, 0);
    endtask

    task automatic test_stall_toggle();
        set_bresp_ok();
        run_cmd(10'h300, 8'd7, 3'd3, 3'b010, 4'd1, 12'h480, 1, 0);
    endtask

    task automatic test_error_resp();
        set_bresp_ok();
        bresp_tab[1] = 2'b10;
        run_cmd(10'h008, 8'd0, 3'd3, 3'b011, 4'd2, 12'h7A0, 0, 0);
        set_bresp_ok();
        run_cmd(10'h00C, 8'd2, 3'd3, 3'b100, 4'd2, 12'h7B0, 2, 0);
    endtask

    task automatic test_wrap();
        set_bresp_ok();
        run_cmd(10'h100, 8'd3, 3'd3, 3'b000, 4'd1, 12'hFFE, 0, 0);
    endtask

    task automatic test_num_zero();
        set_bresp_ok();
        run_cmd(10'h0F0, 8'd2, 3'd3, 3'b001, 4'd0, 12'h333, 2, 0);
    endtask

    task automatic test_reset_mid_w();
        set_bresp_ok();
        run_cmd(10'h200, 8'd7, 3'd3, 3'b000, 4'd4, 12'h500, 2, 12);
        @(negedge clk);
        drive_idle();
        rst = 1'b1;
        #1;
        check_idle_outputs("mid_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_cmd(10'h210, 8'd1, 3'd3, 3'b000, 4'd1, 12'hA00, 0, 0);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 16; i++) bresp_tab[i] = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            run_cmd(10'($urandom), 8'($urandom_range(0, 15)), 3'($urandom), 3'($urandom_range(0, 4)),
                    4'($urandom), 12'($urandom), 2, 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) oram[i] = {$urandom, $urandom};
        set_bresp_ok();
        oram_rd_data = '0;
        test_reset();
        test_single_burst();
        test_multi_burst();
        test_stall_toggle();
        test_error_resp();
        test_wrap();
        test_num_zero();
        test_reset_mid_w();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
